// File: rtl/des_word_assembler_pkg.sv
// Shared constants and width check for the serial word assembler.
// Imported by the assembler top and its slip controller.
package des_word_assembler_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;
  localparam int CNT_W     = 4;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/des_slip_ctrl.sv
// Bitslip edge detect and slip-pending flag.
// A new request wins over consumption on the same edge.
module des_slip_ctrl (
  input  logic C,
  input  logic R,
  input  logic BITSLIP,
  input  logic E,
  output logic SP
);

  logic bs_d;
  logic rise;

  assign rise = BITSLIP & ~bs_d;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      bs_d <= 1'b0;
      SP   <= 1'b0;
    end else begin
      bs_d <= BITSLIP;
      SP   <= rise | (SP & ~E);
    end
  end

endmodule

// File: rtl/des_word_assembler.sv
// Serial-to-parallel word assembler, MSB first,
// with bitslip alignment of the word boundary.
module des_word_assembler
  import des_word_assembler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             D,
  input  logic             E,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] Q,
  output logic             DATA_VALID
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("des_word_assembler: WIDTH out of range");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // only the low WIDTH-1 bits of the shift register are ever read back
  logic [WIDTH-2:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             sp;

  des_slip_ctrl u_slip (
    .C       (C),
    .R       (R),
    .BITSLIP (BITSLIP),
    .E       (E),
    .SP      (sp)
  );

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      sr         <= '0;
      cnt        <= '0;
      Q          <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      if (E) begin
        sr <= {sr[WIDTH-3:0], D};
        if (!sp) begin
          if (cnt == LAST) begin
            Q          <= {sr, D};
            DATA_VALID <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
